gravity_tick_gen: RTL and testbench
===================================

# gravity_tick_gen

Converts the free-running divided clock bits from the clock divider (the slow and fast block-down taps) into clean, single-clock-domain gravity events for the game core. Both taps are sampled as data, synchronised and edge-detected, then gated by a small state machine. The state machine issues drop requests over a req/ack handshake, honours soft-drop and pause, and runs a lock-delay countdown once the active piece has landed. Sits between the clock divider and the piece-movement controller.

## Interface
- LOCK_TICKS, 4, fast-tap rising edges spent in LANDED before lock_pulse (1..255)
- OVR_W, 8, width of the saturating overrun counter
- clk  input  1  system clock (all logic on rising edge)
- rst  input  1  asynchronous, active-high reset
- tick_slow_src  input  1  slow block-down tap, treated as asynchronous data
- tick_fast_src  input  1  fast block-down tap, treated as asynchronous data
- soft_drop  input  1  level; selects fast tap for gravity while in FALL
- pause  input  1  level; freezes gravity and lock delay
- landed  input  1  level from movement controller; piece is resting on stack/floor
- drop_ack  input  1  consumer accepts the pending drop request
- drop_req  output  1  drop request, held until acknowledged
- lock_pulse  output  1  one-cycle pulse: lock delay expired, commit piece
- state_o  output  2  current FSM state encoding
- overrun_cnt  output  OVR_W  gravity ticks lost because a request was still pending

## Operation
- Each tap: 2-FF synchroniser, plus a previous-value register; rise = sync2 & ~prev. Only rising edges count.
- gravity tick = FALL && (soft_drop ? rise_fast : rise_slow).
- lock tick = LANDED && rise_fast.
- States: PAUSED=0, FALL=1, LANDED=2 (3 unused, decodes to FALL).
  - Any state, pause=1 -> PAUSED (highest priority).
  - PAUSED, pause=0 -> FALL; lock counter cleared.
  - FALL, landed=1 -> LANDED; lock counter cleared.
  - LANDED, landed=0 -> FALL; lock counter cleared, no lock_pulse.
  - LANDED, lock tick while counter == LOCK_TICKS-1 -> lock_pulse=1 for that cycle, counter cleared, -> FALL.
  - LANDED, other lock tick -> counter+1.
- drop_req: set on gravity tick; cleared on a cycle with drop_ack=1 and no gravity tick. If gravity tick and drop_ack coincide, drop_req stays 1 (new request, no overrun). drop_ack while drop_req=0 is ignored.
- Overrun: gravity tick while drop_req=1 and drop_ack=0 -> overrun_cnt+1, saturating at all-ones; drop_req stays 1. Cleared only by rst.
- A pending drop_req survives transitions to PAUSED/LANDED; it is still retired by drop_ack.
- Lock counter width: ceil(log2(LOCK_TICKS+1)); never exceeds LOCK_TICKS-1.

## Timing
- Reset values: drop_req=0, lock_pulse=0, state_o=PAUSED... no: state_o=FALL(1), overrun_cnt=0, synchronisers/prev=0, lock counter=0.
- Reset is asynchronous assert; deassertion is assumed synchronous to clk upstream. Reset mid-request drops the request and counter.
- Latency: tap first sampled high at edge k -> rise visible in cycle after edge k+1 -> drop_req high after edge k+2 (3 edges). Same latency for lock_pulse relative to the final fast-tap rise.
- drop_req falls after the edge that samples drop_ack=1.
- lock_pulse is registered, exactly one cycle wide.
- State transitions take effect on the edge after the qualifying input is sampled; rise events in the same cycle are evaluated against the pre-transition state.

## Structure
- Package gravity_pkg: state encoding constants (PAUSED, FALL, LANDED), default LOCK_TICKS, OVR_W.
- One sub-module: edge_sync (2-FF synchroniser + rise detector, clk/rst, in, rise out), instantiated once per tap.
- Top: FSM, lock counter, req/ack register, overrun counter.

## Test plan
- Reset, pause=0, landed=0, slow tap toggling: one drop_req per slow rise, 3 edges after the tap is sampled high; ack each -> overrun_cnt stays 0.
- soft_drop=1: requests follow fast-tap rises; no acks for 3 fast rises -> drop_req=1 throughout, overrun_cnt=2.
- landed=1 with LOCK_TICKS=4: exactly one lock_pulse on 4th fast rise, state returns to FALL; landed dropped after 2 rises -> no lock_pulse, counter restarts at 0 on next landing.
- pause=1 in LANDED after 3 rises, release, re-land -> lock needs 4 fresh rises; no drop_req while paused.
- Gravity tick coinciding with drop_ack -> drop_req stays high, overrun unchanged; force 300 overruns -> overrun_cnt saturates at 255.
- Assert rst mid-LANDED with drop_req=1 -> all outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/gravity_pkg.sv
// Shared encodings and defaults for the gravity tick generator.
package gravity_pkg;

  // FSM state encoding; the unused code 2'd3 is decoded as FALL.
  typedef enum logic [1:0] {
    PAUSED = 2'd0,
    FALL   = 2'd1,
    LANDED = 2'd2
  } state_t;

  localparam int unsigned LOCK_TICKS_DEF = 4;
  localparam int unsigned OVR_W_DEF      = 8;

endpackage

// File: rtl/gravity_tick_gen_edge_sync.sv
// Two-flop synchroniser for an asynchronous tap plus a rising-edge detector.
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic rise
);

  logic sync1_q;
  logic sync2_q;
  logic prev_q;

  // Synchronise the tap and remember the previous synchronised value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;

endmodule

// File: rtl/gravity_tick_gen.sv
// Turns divided-clock taps into gravity drop requests and lock-delay pulses.
module gravity_tick_gen
  import gravity_pkg::*;
#(
  parameter int unsigned LOCK_TICKS = LOCK_TICKS_DEF,
  parameter int unsigned OVR_W      = OVR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_slow_src,
  input  logic             tick_fast_src,
  input  logic             soft_drop,
  input  logic             pause,
  input  logic             landed,
  input  logic             drop_ack,
  output logic             drop_req,
  output logic             lock_pulse,
  output logic [1:0]       state_o,
  output logic [OVR_W-1:0] overrun_cnt
);

  localparam int unsigned     CNT_W    = $clog2(LOCK_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TICKS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             lock_fire;
  logic             rise_slow;
  logic             rise_fast;
  logic             in_fall;
  logic             in_landed;
  logic             grav_tick;
  logic             lock_tick;
  logic             req_q;
  logic [OVR_W-1:0] ovr_q;

  edge_sync u_sync_slow (
    .clk  (clk),
    .rst  (rst),
    .in   (tick_slow_src),
    .rise (rise_slow)
  );

  edge_sync u_sync_fast (
    .clk  (clk),
    .rst  (rst),
    .in   (tick_fast_src),
    .rise (rise_fast)
  );

  // The spare encoding behaves as FALL so a corrupted state still drops pieces.
  assign in_landed = (state_q == LANDED);
  assign in_fall   = (state_q != PAUSED) && !in_landed;
  assign grav_tick = in_fall && (soft_drop ? rise_fast : rise_slow);
  assign lock_tick = in_landed && rise_fast;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FALL;
    else     state_q <= state_d;
  end

  // Next-state decode; pause overrides everything.
  always_comb begin
    state_d = state_q;
    if (pause) begin
      state_d = PAUSED;
    end else begin
      case (state_q)
        PAUSED: state_d = FALL;
        LANDED: begin
          if (!landed)                             state_d = FALL;
          else if (lock_tick && cnt_q == CNT_LAST) state_d = FALL;
          else                                     state_d = LANDED;
        end
        default: state_d = landed ? LANDED : FALL;
      endcase
    end
  end

  // Lock-delay counter update and lock pulse decode.
  // While paused from LANDED the count is held; it is cleared on leaving PAUSED.
  always_comb begin
    cnt_d     = cnt_q;
    lock_fire = 1'b0;
    case (state_q)
      LANDED: begin
        if (state_d == LANDED) begin
          if (lock_tick) cnt_d = cnt_q + CNT_W'(1);
        end else if (state_d == FALL) begin
          cnt_d     = '0;
          lock_fire = landed && lock_tick;
        end
      end
      default: begin
        if (state_d != state_q) cnt_d = '0;
      end
    endcase
  end

  // Lock counter and registered lock pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q      <= '0;
      lock_pulse <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      lock_pulse <= lock_fire;
    end
  end

  // Drop request handshake and saturating overrun counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_q <= 1'b0;
      ovr_q <= '0;
    end else begin
      if (grav_tick)     req_q <= 1'b1;
      else if (drop_ack) req_q <= 1'b0;
      if (grav_tick && req_q && !drop_ack && !(&ovr_q))
        ovr_q <= ovr_q + OVR_W'(1);
    end
  end

  assign drop_req    = req_q;
  assign overrun_cnt = ovr_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_gravity_tick_gen.sv
// Directed self-checking bench for gravity_tick_gen.
module tb_gravity_tick_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick_slow_src;
  logic       tick_fast_src;
  logic       soft_drop;
  logic       pause;
  logic       landed;
  logic       drop_ack;
  logic       drop_req;
  logic       lock_pulse;
  logic [1:0] state_o;
  logic [7:0] overrun_cnt;

  int checks = 0;
  int errors = 0;

  gravity_tick_gen #(
    .LOCK_TICKS (4),
    .OVR_W      (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .tick_slow_src (tick_slow_src),
    .tick_fast_src (tick_fast_src),
    .soft_drop     (soft_drop),
    .pause         (pause),
    .landed        (landed),
    .drop_ack      (drop_ack),
    .drop_req      (drop_req),
    .lock_pulse    (lock_pulse),
    .state_o       (state_o),
    .overrun_cnt   (overrun_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle-high pulse on a tap, then one more edge so the rise is consumed.
  task automatic pulse_slow();
    tick_slow_src = 1'b1; tick();
    tick_slow_src = 1'b0; tick();
    tick();
  endtask

  task automatic pulse_fast();
    tick_fast_src = 1'b1; tick();
    tick_fast_src = 1'b0; tick();
    tick();
  endtask

  task automatic ack();
    drop_ack = 1'b1; tick();
    drop_ack = 1'b0;
  endtask

  initial begin
    rst = 1'b1; tick_slow_src = 0; tick_fast_src = 0;
    soft_drop = 0; pause = 0; landed = 0; drop_ack = 0;
    tick(); tick();
    chk("rst_state", 32'(state_o), 32'd1);
    chk("rst_req", 32'(drop_req), 32'd0);
    chk("rst_lock", 32'(lock_pulse), 32'd0);
    chk("rst_ovr", 32'(overrun_cnt), 32'd0);
    rst = 1'b0;
    tick();

    // Slow gravity: request appears on the third edge after the tap is sampled.
    for (int i = 0; i < 2; i++) begin
      tick_slow_src = 1'b1; tick();
      tick_slow_src = 1'b0; tick();
      chk("slow_latency_lo", 32'(drop_req), 32'd0);
      tick();
      chk("slow_req_hi", 32'(drop_req), 32'd1);
      ack();
      chk("slow_ack_clr", 32'(drop_req), 32'd0);
    end
    chk("slow_ovr0", 32'(overrun_cnt), 32'd0);
    pulse_fast();
    chk("fast_ignored", 32'(drop_req), 32'd0);

    // Soft drop: three unacknowledged fast rises -> two overruns.
    soft_drop = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pulse_fast();
      chk("soft_req_held", 32'(drop_req), 32'd1);
    end
    chk("soft_ovr2", 32'(overrun_cnt), 32'd2);
    ack();
    chk("soft_ack_clr", 32'(drop_req), 32'd0);
    soft_drop = 1'b0;

    // Lock delay: fourth fast rise in LANDED fires exactly once.
    landed = 1'b1; tick();
    chk("land_state", 32'(state_o), 32'd2);
    for (int i = 0; i < 3; i++) begin
      pulse_fast();
      chk("lock_wait", 32'(lock_pulse), 32'd0);
    end
    pulse_fast();
    chk("lock_fire", 32'(lock_pulse), 32'd1);
    chk("lock_to_fall", 32'(state_o), 32'd1);
    tick();
    chk("lock_one_cycle", 32'(lock_pulse), 32'd0);
    chk("reland", 32'(state_o), 32'd2);

    // Leaving LANDED after two rises restarts the count.
    pulse_fast(); pulse_fast();
    landed = 1'b0; tick();
    chk("unland_state", 32'(state_o), 32'd1);
    chk("unland_nolock", 32'(lock_pulse), 32'd0);
    landed = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      pulse_fast();
      chk("restart_wait", 32'(lock_pulse), 32'd0);
    end
    pulse_fast();
    chk("restart_fire", 32'(lock_pulse), 32'd1);
    tick();

    // Pause after three rises: lock needs four fresh rises afterwards.
    chk("pre_pause_state", 32'(state_o), 32'd2);
    pulse_fast(); pulse_fast(); pulse_fast();
    pause = 1'b1; tick();
    chk("paused_state", 32'(state_o), 32'd0);
    pulse_slow(); pulse_fast();
    chk("paused_noreq", 32'(drop_req), 32'd0);
    chk("paused_nolock", 32'(lock_pulse), 32'd0);
    pause = 1'b0; tick();
    chk("unpause_fall", 32'(state_o), 32'd1);
    tick();
    chk("unpause_land", 32'(state_o), 32'd2);
    for (int i = 0; i < 3; i++) begin
      pulse_fast();
      chk("fresh_wait", 32'(lock_pulse), 32'd0);
    end
    pulse_fast();
    chk("fresh_fire", 32'(lock_pulse), 32'd1);
    landed = 1'b0; tick();
    chk("after_fire_fall", 32'(state_o), 32'd1);

    // Gravity tick coinciding with ack keeps the request, no overrun.
    pulse_slow();
    chk("coin_req", 32'(drop_req), 32'd1);
    tick_slow_src = 1'b1; tick();
    tick_slow_src = 1'b0; tick();
    drop_ack = 1'b1; tick();
    drop_ack = 1'b0;
    chk("coin_req_held", 32'(drop_req), 32'd1);
    chk("coin_ovr", 32'(overrun_cnt), 32'd2);

    // Drive 300 overruns; counter saturates at 255.
    soft_drop = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick_fast_src = 1'b1; tick();
      tick_fast_src = 1'b0; tick();
    end
    tick(); tick();
    chk("ovr_12", 32'(overrun_cnt), 32'd12);
    for (int i = 0; i < 290; i++) begin
      tick_fast_src = 1'b1; tick();
      tick_fast_src = 1'b0; tick();
    end
    tick(); tick();
    chk("ovr_sat", 32'(overrun_cnt), 32'd255);
    chk("ovr_req", 32'(drop_req), 32'd1);
    soft_drop = 1'b0;

    // Asynchronous reset mid-LANDED with a pending request.
    landed = 1'b1; tick();
    chk("pre_rst_state", 32'(state_o), 32'd2);
    pulse_fast();
    rst = 1'b1;
    #1;
    chk("arst_state", 32'(state_o), 32'd1);
    chk("arst_req", 32'(drop_req), 32'd0);
    chk("arst_ovr", 32'(overrun_cnt), 32'd0);
    chk("arst_lock", 32'(lock_pulse), 32'd0);
    tick();
    rst = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
